// File: rtl/simdev_req_ctrl.sv
// rtl/simdev_req_ctrl.sv - request sequencer for the simple adder device
// One request in flight: latch operands, pulse dev_ena, await dev_ok or timeout, return response.
module simdev_req_ctrl #(
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 32,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [7:0]       req_a,
   input  logic [7:0]       req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             dev_ena,
   output logic [7:0]       dev_a,
   output logic [7:0]       dev_b,
   input  logic [7:0]       dev_out,
   input  logic             dev_ok,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t     state;
   logic [7:0] timer;

   // Ready is decoded so a request can be taken in the very first IDLE cycle.
   assign req_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         dev_ena   <= 1'b0;
         dev_a     <= '0;
         dev_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_tag   <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         done_cnt  <= '0;
         err_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  dev_a   <= req_a;
                  dev_b   <= req_b;
                  rsp_tag <= req_tag;
                  dev_ena <= 1'b1;
                  busy    <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               dev_ena <= 1'b0;
               timer   <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               timer <= timer + 8'd1;
               // A completion in the last watchdog cycle still counts as a normal result.
               if (dev_ok) begin
                  rsp_data  <= dev_out;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (timer == 8'(TIMEOUT - 1)) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
                  if (rsp_err) begin
                     if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                  end else begin
                     if (done_cnt != '1) done_cnt <= done_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simdev_req_ctrl.sv
// tb/tb_simdev_req_ctrl.sv - self-checking bench for simdev_req_ctrl
// Transactions are predicted from device delay, watchdog limit and handshake timing.
module tb_simdev_req_ctrl;

   localparam int TAG_W   = 4;
   localparam int TIMEOUT = 32;
   localparam int CNT_W   = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid, req_ready;
   logic [7:0]       req_a, req_b;
   logic [TAG_W-1:0] req_tag;
   logic             dev_ena;
   logic [7:0]       dev_a, dev_b, dev_out;
   logic             dev_ok;
   logic             rsp_valid, rsp_ready;
   logic [7:0]       rsp_data;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_err, busy;
   logic [CNT_W-1:0] done_cnt, err_cnt;

   int vectors = 0;
   int miscompares = 0;
   int exp_done = 0;
   int exp_err = 0;

   simdev_req_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .dev_ena(dev_ena), .dev_a(dev_a), .dev_b(dev_b),
      .dev_out(dev_out), .dev_ok(dev_ok),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
      .busy(busy), .done_cnt(done_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // dly: cycles from the ISSUE cycle to the dev_ok cycle; 0 means the device never answers.
   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] tag,
                          input int dly, input int hold, input logic pend,
                          input logic [7:0] na, input logic [7:0] nb, input logic [TAG_W-1:0] ntag);
      int         exp_t;
      logic [7:0] exp_d;
      logic       exp_e;
      logic [7:0] sum;
      sum = a + b;
      if (dly >= 1 && dly <= TIMEOUT) begin
         exp_t = 2 + dly;
         exp_d = sum;
         exp_e = 1'b0;
      end else begin
         exp_t = 2 + TIMEOUT;
         exp_d = 8'h00;
         exp_e = 1'b1;
      end
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_ready: req_ready=%b want 1", req_ready);
      end
      req_valid = 1'b1; req_a = a; req_b = b; req_tag = tag;
      step;
      req_valid = 1'b0;
      for (int t = 1; t <= exp_t; t++) begin
         vectors++;
         if ({dev_ena, rsp_valid, busy, dev_a, dev_b} !== {t == 1, t == exp_t, 1'b1, a, b}) begin
            miscompares++;
            $display("FAIL cyc%0d: ena/valid/busy/a/b=%b/%b/%b/%h/%h want %b/%b/1/%h/%h",
                     t, dev_ena, rsp_valid, busy, dev_a, dev_b, t == 1, t == exp_t, a, b);
         end
         if (t < exp_t) begin
            dev_ok  = (dly >= 1 && t == 1 + dly);
            dev_out = dev_ok ? sum : 8'($urandom);
            step;
            dev_ok  = 1'b0;
         end
      end
      vectors++;
      if ({rsp_data, rsp_tag, rsp_err} !== {exp_d, tag, exp_e}) begin
         miscompares++;
         $display("FAIL rsp: data/tag/err=%h/%h/%b want %h/%h/%b",
                  rsp_data, rsp_tag, rsp_err, exp_d, tag, exp_e);
      end
      // Late completion during RESP must be ignored.
      dev_ok = 1'b1; dev_out = 8'($urandom);
      req_valid = pend; req_a = na; req_b = nb; req_tag = ntag;
      for (int h = 0; h < hold; h++) begin
         step;
         dev_ok = 1'b0;
         vectors++;
         if ({rsp_valid, rsp_data, rsp_tag, rsp_err, req_ready, dev_ena, dev_a, dev_b,
              done_cnt, err_cnt} !==
             {1'b1, exp_d, tag, exp_e, 1'b0, 1'b0, a, b, CNT_W'(exp_done), CNT_W'(exp_err)}) begin
            miscompares++;
            $display("FAIL hold%0d: valid=%b data=%h tag=%h err=%b rdy=%b ena=%b done=%0d errc=%0d want 1/%h/%h/%b/0/0/%0d/%0d",
                     h, rsp_valid, rsp_data, rsp_tag, rsp_err, req_ready, dev_ena, done_cnt, err_cnt,
                     exp_d, tag, exp_e, exp_done, exp_err);
         end
      end
      rsp_ready = 1'b1;
      step;
      rsp_ready = 1'b0;
      dev_ok = 1'b0;
      if (exp_e) exp_err++; else exp_done++;
      vectors++;
      if ({rsp_valid, busy, req_ready, dev_ena, done_cnt, err_cnt} !==
          {1'b0, 1'b0, 1'b1, 1'b0, CNT_W'(exp_done), CNT_W'(exp_err)}) begin
         miscompares++;
         $display("FAIL after_rsp: valid=%b busy=%b rdy=%b ena=%b done=%0d err=%0d want 0/0/1/0/%0d/%0d",
                  rsp_valid, busy, req_ready, dev_ena, done_cnt, err_cnt, exp_done, exp_err);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
      dev_out = '0; dev_ok = 1'b0; rsp_ready = 1'b0;
      repeat (3) step;
      vectors++;
      if ({dev_ena, dev_a, dev_b, rsp_valid, rsp_data, rsp_tag, rsp_err, busy, done_cnt, err_cnt,
           req_ready} !== '0) begin
         miscompares++;
         $display("FAIL reset: ena=%b a=%h b=%h valid=%b data=%h tag=%h err=%b busy=%b done=%0d errc=%0d rdy=%b want all 0",
                  dev_ena, dev_a, dev_b, rsp_valid, rsp_data, rsp_tag, rsp_err, busy, done_cnt, err_cnt, req_ready);
      end
      rst = 1'b0;
      step;
   endtask

   task automatic test_basic;
      run_txn(8'h12, 8'h34, 4'd3, 9, 0, 1'b0, 8'h00, 8'h00, 4'd0);
      run_txn(8'hF0, 8'h20, 4'd7, 9, 1, 1'b0, 8'h00, 8'h00, 4'd0);
   endtask

   task automatic test_timeout;
      run_txn(8'h0A, 8'h0B, 4'd9, 0, 2, 1'b0, 8'h00, 8'h00, 4'd0);
      dev_ok = 1'b1; dev_out = 8'hAA;
      step;
      dev_ok = 1'b0;
      step;
      vectors++;
      if ({busy, rsp_valid, dev_ena, done_cnt, err_cnt} !==
          {1'b0, 1'b0, 1'b0, CNT_W'(exp_done), CNT_W'(exp_err)}) begin
         miscompares++;
         $display("FAIL idle_late_ok: busy=%b valid=%b ena=%b done=%0d err=%0d want 0/0/0/%0d/%0d",
                  busy, rsp_valid, dev_ena, done_cnt, err_cnt, exp_done, exp_err);
      end
   endtask

   task automatic test_backpressure;
      run_txn(8'h01, 8'h02, 4'd5, 4, 20, 1'b1, 8'h33, 8'h44, 4'd6);
      run_txn(8'h33, 8'h44, 4'd6, 3, 0, 1'b0, 8'h00, 8'h00, 4'd0);
   endtask

   task automatic test_boundary;
      run_txn(8'h50, 8'h05, 4'd2, TIMEOUT, 0, 1'b0, 8'h00, 8'h00, 4'd0);
      run_txn(8'h11, 8'h22, 4'd4, TIMEOUT + 1, 0, 1'b0, 8'h00, 8'h00, 4'd0);
   endtask

   task automatic test_async_reset;
      req_valid = 1'b1; req_a = 8'h77; req_b = 8'h66; req_tag = 4'd8;
      step;
      req_valid = 1'b0;
      repeat (5) step;
      #2;
      rst = 1'b1;
      #1;
      exp_done = 0; exp_err = 0;
      vectors++;
      if ({dev_ena, dev_a, dev_b, rsp_valid, rsp_data, rsp_tag, rsp_err, busy, done_cnt, err_cnt,
           req_ready} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: ena=%b a=%h b=%h valid=%b data=%h tag=%h err=%b busy=%b done=%0d errc=%0d rdy=%b want all 0",
                  dev_ena, dev_a, dev_b, rsp_valid, rsp_data, rsp_tag, rsp_err, busy, done_cnt, err_cnt, req_ready);
      end
      step;
      rst = 1'b0;
      step;
      run_txn(8'h21, 8'h43, 4'd1, 5, 0, 1'b0, 8'h00, 8'h00, 4'd0);
   endtask

   task automatic test_random;
      logic [7:0]       ca, cb, na, nb;
      logic [TAG_W-1:0] ct, nt;
      int               dly;
      ca = 8'($urandom); cb = 8'($urandom); ct = TAG_W'($urandom);
      for (int i = 0; i < 12; i++) begin
         na = 8'($urandom); nb = 8'($urandom); nt = TAG_W'($urandom);
         dly = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 4));
         run_txn(ca, cb, ct, dly, int'($urandom_range(0, 3)), i != 11, na, nb, nt);
         ca = na; cb = nb; ct = nt;
      end
      req_valid = 1'b0;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_timeout;
      test_backpressure;
      test_boundary;
      test_async_reset;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
